wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the register file: produces its write port
//  (wr_en/wr_addr/wr_data -> Write_reg/Reg_toWrite/Write_data). Merges single-cycle
//  ALU results with results from the multi-cycle coprocessor (AES unit, mul/div).
//  Coprocessor results are buffered in a small FIFO. A 32-bit busy scoreboard lets
//  decode detect RAW hazards on pending coprocessor destinations.
// PARAMETERS
//  DATA_W      32  result/register data width
//  ADDR_W      5   register index width (32 registers)
//  DEPTH       2   coprocessor result FIFO entries (>=1)
//  STARVE_MAX  4   consecutive ALU-won cycles with FIFO non-empty before alu_hold
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, asynchronous, active-low
//  alu_valid     in   1       ALU result present this cycle (cannot be stalled)
//  alu_rd        in   ADDR_W  ALU destination register
//  alu_data      in   DATA_W  ALU result
//  cop_valid     in   1       coprocessor result offered
//  cop_ready     out  1       FIFO accepts; = (count != DEPTH), combinational
//  cop_rd        in   ADDR_W  coprocessor destination register
//  cop_data      in   DATA_W  coprocessor result
//  issue_valid   in   1       decode issues a coprocessor op this cycle
//  issue_rd      in   ADDR_W  its destination register
//  busy          out  32      busy[r]=1: coprocessor write to r outstanding
//  alu_hold      out  1       registered; request one ALU bubble so FIFO drains
//  issue_err     out  1       registered 1-cycle pulse: issue to already-busy reg
//  wr_en         out  1       register-file write enable
//  wr_addr       out  ADDR_W  register-file write index
//  wr_data       out  DATA_W  register-file write data
// BEHAVIOUR
//  - Reset (rst=0, async): wr_en=0, wr_addr=0, wr_data=0, FIFO empty (cop_ready=1),
//    busy=0, alu_hold=0, issue_err=0, starve counter=0. Mid-operation reset drops
//    all FIFO contents and pending busy bits.
//  - Output regs, 1-cycle latency. Per edge, priority:
//    1) alu_valid: wr_en<=(alu_rd!=0), wr_addr<=alu_rd, wr_data<=alu_data; no pop.
//    2) else FIFO non-empty: pop head; wr_en<=(head_rd!=0), addr/data from head.
//    3) else wr_en<=0; wr_addr/wr_data hold their previous values.
//  - Push: cop_valid&&cop_ready. Result with cop_rd==0 is accepted but not enqueued.
//    Push and pop in the same cycle are allowed; count unchanged.
//    cop_ready is from count at cycle start: no push when full, even if popping.
//  - FIFO is strictly in order; pointers wrap modulo DEPTH.
//  - Scoreboard: issue_valid&&issue_rd!=0 sets busy[issue_rd].
//    A pop clears busy[head_rd] on the same edge that wr_en rises.
//    Set and clear of the same register in one cycle: set wins.
//    Issue while busy[issue_rd]=1: busy stays 1, issue_err=1 next cycle.
//  - Starvation: the counter increments on each edge where alu_valid=1 and the FIFO
//    is non-empty, saturating at STARVE_MAX. It clears on any cycle with
//    alu_valid=0 or FIFO empty.
//    alu_hold<=1 when the next count reaches STARVE_MAX, else 0.
//    When asserted, upstream withholds alu_valid for >=1 cycle.
//  - Never two register-file writes in one cycle; ALU data never delayed or dropped.
// TESTING
//  1 ALU: alu_valid, rd=5, data=0x00001234 -> next cycle wr_en=1, wr_addr=5,
//    wr_data=0x00001234.
//  2 Collision: alu rd=3 and cop push rd=7 (0xCAFEF00D) in same cycle ->
//    cycle+1 writes r3, cycle+2 writes r7=0xCAFEF00D, busy[7] 1->0 at cycle+2 edge.
//  3 Full/starve (DEPTH=2, STARVE_MAX=4): alu_valid held, push rd 8 then 9 ->
//    cop_ready=0; alu_hold=1 after 4th ALU cycle; alu_valid=0 -> r8 then r9,
//    cop_ready=1 after first pop.
//  4 Zero reg: alu rd=0 -> wr_en=0; cop rd=0 -> accepted, count unchanged, no write.
//  5 Scoreboard: busy[9]=1, issue rd=9 same cycle as pop of rd=9 -> r9 written,
//    busy[9] stays 1, issue_err=1 next cycle.
//  6 Reset mid-op: FIFO holding 2 entries, rst=0 async -> wr_en=0, busy=0 and
//    cop_ready=1 immediately; after release no stale write occurs.

Source files
------------

// File: rtl/wb_arbiter.sv
// Small in-order FIFO used to buffer coprocessor results ahead of writeback.
// Latency: a pushed entry is visible at dout on the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; full/empty are exported.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH (which need not be a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end
endmodule

// Writeback arbiter: merges unstallable ALU results with buffered coprocessor results into the regfile write port.
// Latency: one cycle from winning arbitration to wr_en/wr_addr/wr_data; ALU always wins.
// Backpressure: cop_ready drops when the result FIFO is full; alu_hold asks upstream for an ALU bubble on starvation.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              cop_valid,
  output logic              cop_ready,
  input  logic [ADDR_W-1:0] cop_rd,
  input  logic [DATA_W-1:0] cop_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [31:0]       busy,
  output logic              alu_hold,
  output logic              issue_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]        head_rd;
  logic [DATA_W-1:0]        head_data;
  logic [31:0]              busy_next;
  logic                     issue_err_next;
  logic [SW-1:0]            starve;
  logic [SW-1:0]            starve_next;

  // Writes to r0 are discarded at the door: they are acknowledged but never occupy a slot.
  assign cop_ready = !fifo_full;
  assign push      = cop_valid && cop_ready && (cop_rd != '0);
  assign pop       = !alu_valid && !fifo_empty;
  assign head_rd   = head[ADDR_W+DATA_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  wb_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cop_rd, cop_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Scoreboard update: a pop clears its destination, a fresh issue sets it, set wins on conflict.
  always_comb begin
    busy_next      = busy;
    issue_err_next = 1'b0;
    if (pop) busy_next[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
      issue_err_next      = busy[issue_rd];
    end
  end

  // Starvation count of consecutive cycles where the ALU beat a waiting coprocessor result.
  always_comb begin
    starve_next = '0;
    if (alu_valid && !fifo_empty)
      starve_next = (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
  end

  // Regfile write port: ALU first, then FIFO head; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (alu_valid) begin
      wr_en   <= (alu_rd != '0);
      wr_addr <= alu_rd;
      wr_data <= alu_data;
    end else if (!fifo_empty) begin
      wr_en   <= (head_rd != '0);
      wr_addr <= head_rd;
      wr_data <= head_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Scoreboard, hazard pulse and starvation state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      issue_err <= 1'b0;
      starve    <= '0;
      alu_hold  <= 1'b0;
    end else begin
      busy      <= busy_next;
      issue_err <= issue_err_next;
      starve    <= starve_next;
      alu_hold  <= (starve_next == SW'(STARVE_MAX));
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every cycle, directed scenarios with literal checks, then random traffic.
// Latency: model predicts the post-edge register values and is compared on the falling edge.
// Backpressure: stimulus honours cop_ready implicitly (model drops unaccepted offers) and withholds ALU when the model predicts alu_hold.
module tb_wb_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        cop_valid = 1'b0;
  logic        cop_ready;
  logic [4:0]  cop_rd = '0;
  logic [31:0] cop_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] busy;
  logic        alu_hold;
  logic        issue_err;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  int          m_starve;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_hold;
  logic        m_err;

  wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .cop_valid   (cop_valid),
    .cop_ready   (cop_ready),
    .cop_rd      (cop_rd),
    .cop_data    (cop_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .alu_hold    (alu_hold),
    .issue_err   (issue_err),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ALU wins, else oldest queued result; r0 never queued or written.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_busy = '0; m_starve = 0; m_en = 0; m_addr = '0; m_data = '0; m_hold = 0; m_err = 0;
    end else begin
      automatic int          occ       = q.size();
      automatic bit          had_entry = (occ > 0);
      automatic bit          accepts   = (occ < DEPTH);
      automatic logic [31:0] nb        = m_busy;
      automatic ent_t        e;
      m_err = issue_valid && (issue_rd != 0) && m_busy[issue_rd];
      if (alu_valid) begin
        m_en = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
      end else if (had_entry) begin
        e = q.pop_front();
        m_en = (e.rd != 0); m_addr = e.rd; m_data = e.data;
        nb[e.rd] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      if (cop_valid && accepts && cop_rd != 0) begin
        e.rd = cop_rd; e.data = cop_data;
        q.push_back(e);
      end
      if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      if (alu_valid && had_entry) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else m_starve = 0;
      m_hold = (m_starve == STARVE_MAX);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started && rst) begin
      chk("m_wr_en",     64'(wr_en),     64'(m_en));
      chk("m_wr_addr",   64'(wr_addr),   64'(m_addr));
      chk("m_wr_data",   64'(wr_data),   64'(m_data));
      chk("m_busy",      64'(busy),      64'(m_busy));
      chk("m_cop_ready", 64'(cop_ready), 64'(q.size() < DEPTH));
      chk("m_alu_hold",  64'(alu_hold),  64'(m_hold));
      chk("m_issue_err", 64'(issue_err), 64'(m_err));
    end
  end

  task automatic idle();
    alu_valid = 0; cop_valid = 0; issue_valid = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    started = 1'b1;
    step();
    // reset state
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cop_ready", 64'(cop_ready), 64'd1);
    chk("rst_alu_hold", 64'(alu_hold), 64'd0);
    chk("rst_issue_err", 64'(issue_err), 64'd0);

    // 1: plain ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_1234;
    step(); idle();
    chk("t1_wr_en", 64'(wr_en), 64'd1);
    chk("t1_wr_addr", 64'(wr_addr), 64'd5);
    chk("t1_wr_data", 64'(wr_data), 64'h1234);
    step();

    // 2: ALU/coprocessor collision
    issue_valid = 1; issue_rd = 7;
    step();
    chk("t2_busy_set", 64'(busy[7]), 64'd1);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333_0003;
    cop_valid = 1; cop_rd = 7; cop_data = 32'hCAFE_F00D;
    step(); idle();
    chk("t2_c1_addr", 64'(wr_addr), 64'd3);
    chk("t2_c1_busy", 64'(busy[7]), 64'd1);
    step();
    chk("t2_c2_en", 64'(wr_en), 64'd1);
    chk("t2_c2_addr", 64'(wr_addr), 64'd7);
    chk("t2_c2_data", 64'(wr_data), 64'hCAFE_F00D);
    chk("t2_c2_busy", 64'(busy[7]), 64'd0);
    step();

    // 3: FIFO fills under continuous ALU traffic, starvation raises alu_hold
    alu_valid = 1; alu_rd = 1; alu_data = 32'h0101_0101;
    cop_valid = 1; cop_rd = 8; cop_data = 32'h0000_0088;
    step();
    chk("t3_ready_1", 64'(cop_ready), 64'd1);
    cop_rd = 9; cop_data = 32'h0000_0099;
    step();
    chk("t3_ready_full", 64'(cop_ready), 64'd0);
    cop_valid = 0;
    step(); step();
    chk("t3_hold_early", 64'(alu_hold), 64'd0);
    step();
    chk("t3_hold", 64'(alu_hold), 64'd1);
    alu_valid = 0;
    step();
    chk("t3_pop1_addr", 64'(wr_addr), 64'd8);
    chk("t3_pop1_data", 64'(wr_data), 64'h88);
    chk("t3_ready_after", 64'(cop_ready), 64'd1);
    step();
    chk("t3_pop2_addr", 64'(wr_addr), 64'd9);
    chk("t3_pop2_data", 64'(wr_data), 64'h99);
    step();
    chk("t3_idle_en", 64'(wr_en), 64'd0);

    // 4: register zero
    alu_valid = 1; alu_rd = 0; alu_data = 32'h0000_0044;
    step();
    chk("t4_alu_r0_en", 64'(wr_en), 64'd0);
    alu_valid = 0;
    cop_valid = 1; cop_rd = 0; cop_data = 32'h0000_0055;
    step(); idle();
    chk("t4_cop_r0_ready", 64'(cop_ready), 64'd1);
    step();
    chk("t4_cop_r0_en", 64'(wr_en), 64'd0);
    chk("t4_data_held", 64'(wr_data), 64'h44);

    // 5: issue to a register whose pending result is popping this cycle
    issue_valid = 1; issue_rd = 9;
    cop_valid = 1; cop_rd = 9; cop_data = 32'h0000_9999;
    step();
    cop_valid = 0;
    step(); idle();
    chk("t5_wr_addr", 64'(wr_addr), 64'd9);
    chk("t5_wr_data", 64'(wr_data), 64'h9999);
    chk("t5_busy9", 64'(busy[9]), 64'd1);
    chk("t5_err", 64'(issue_err), 64'd1);
    step();
    chk("t5_err_clear", 64'(issue_err), 64'd0);

    // 6: asynchronous reset with a full FIFO
    alu_valid = 1; alu_rd = 2; alu_data = 32'h0000_0002;
    cop_valid = 1; cop_rd = 10; cop_data = 32'hA;
    issue_valid = 1; issue_rd = 10;
    step();
    cop_rd = 11; cop_data = 32'hB; issue_rd = 11;
    step();
    chk("t6_full", 64'(cop_ready), 64'd0);
    idle();
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_en", 64'(wr_en), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(cop_ready), 64'd1);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stale", 64'(wr_en), 64'd0);
    end

    // random traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 1500; c++) begin
      step();
      if (c == 700) begin
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
      end
      alu_valid   = m_hold ? 1'b0 : ($urandom_range(0, 99) < 55);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      cop_valid   = ($urandom_range(0, 99) < 60);
      cop_rd      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cop_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = 5'($urandom_range(0, 31));
    end
    step(); idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
